link_credit_arbiter: RTL and testbench

LINK_CREDIT_ARBITER -- requirements
Module: link_credit_arbiter

---
 rtl/link_credit_arbiter_pkg.sv | 14 +
 rtl/credit_counter.sv | 50 +++++
 rtl/link_credit_arbiter.sv | 126 ++++++++++++
 tb/tb_link_credit_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/link_credit_arbiter_pkg.sv
// Shared types and default sizing for the two-source credit-based link arbiter.
package link_credit_arbiter_pkg;

    localparam int unsigned DataLineWidthDef = 40;
    localparam int unsigned FifoDepthDef     = 32;
    localparam int unsigned Log2FifoDepthDef = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/credit_counter.sv
// Link credit counter: starts full, decrements on consume, increments on return,
// and raises a sticky overflow flag when a return arrives at a full count.
module credit_counter
    import link_credit_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = FifoDepthDef,
    parameter int unsigned CNT_W = Log2FifoDepthDef + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_consume,
    input  logic             i_return,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    localparam logic [CNT_W-1:0] Full = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (i_consume && !i_return) begin
            count_d = count_q - 1'b1;
        end else if (i_return && !i_consume) begin
            // A return with every entry already credited is a protocol error, not a count.
            if (count_q == Full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= Full;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule

// File: rtl/link_credit_arbiter.sv
// Two-source packet arbiter onto a credit-flow-controlled link: round-robin between
// packets, locked to one source until its last flit, registered link output.
module link_credit_arbiter
    import link_credit_arbiter_pkg::*;
#(
    parameter int unsigned DATA_LINE_WIDTH = DataLineWidthDef,
    parameter int unsigned FIFO_DEPTH      = FifoDepthDef,
    parameter int unsigned LOG2_FIFO_DEPTH = Log2FifoDepthDef
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_LINE_WIDTH-1:0] i_src0_flit,
    input  logic [DATA_LINE_WIDTH-1:0] i_src1_flit,
    input  logic                       i_src0_valid,
    input  logic                       i_src1_valid,
    input  logic                       i_src0_last,
    input  logic                       i_src1_last,
    output logic                       o_src0_ready,
    output logic                       o_src1_ready,
    output logic [DATA_LINE_WIDTH-1:0] o_link_flit,
    output logic                       o_link_flit_valid,
    input  logic                       i_credit_return,
    output logic [LOG2_FIFO_DEPTH:0]   o_credits,
    output logic [1:0]                 o_grant,
    output logic                       o_credit_err
);

    localparam int unsigned CntW = LOG2_FIFO_DEPTH + 1;

    arb_state_e state_q, state_d;
    logic       ptr_q, ptr_d;

    logic [CntW-1:0] credits;
    logic            have_credit;
    logic [1:0]      grant;
    logic [1:0]      ready;
    logic            accept;
    logic            sel;
    logic            sel_last;

    logic [DATA_LINE_WIDTH-1:0] link_flit_q;
    logic                       link_valid_q;

    assign have_credit = (credits != '0);

    // Owner selection; nothing is granted while reset is held.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (have_credit) begin
                        if (i_src0_valid && i_src1_valid) begin
                            grant = ptr_q ? 2'b10 : 2'b01;
                        end else begin
                            grant = {i_src1_valid, i_src0_valid};
                        end
                    end
                end
                LOCK0:   grant = 2'b01;
                LOCK1:   grant = 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign ready    = have_credit ? grant : 2'b00;
    assign accept   = (i_src0_valid && ready[0]) || (i_src1_valid && ready[1]);
    assign sel      = i_src1_valid && ready[1];
    assign sel_last = sel ? i_src1_last : i_src0_last;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (accept) begin
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = ~sel;
            end else begin
                state_d = sel ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_flit_q  <= '0;
            link_valid_q <= 1'b0;
        end else begin
            link_valid_q <= accept;
            if (accept) begin
                link_flit_q <= sel ? i_src1_flit : i_src0_flit;
            end
        end
    end

    credit_counter #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CntW)
    ) u_credit_counter (
        .clk        (clk),
        .rst        (rst),
        .i_consume  (accept),
        .i_return   (i_credit_return),
        .o_count    (credits),
        .o_overflow (o_credit_err)
    );

    assign o_src0_ready      = ready[0];
    assign o_src1_ready      = ready[1];
    assign o_grant           = grant;
    assign o_credits         = credits;
    assign o_link_flit       = link_flit_q;
    assign o_link_flit_valid = link_valid_q;

endmodule

// File: tb/tb_link_credit_arbiter.sv
// Directed bench for link_credit_arbiter: tie rotation, packet lock, credit
// exhaustion and return timing, simultaneous consume/return, overflow, reset mid-packet.
module tb_link_credit_arbiter;

  localparam int unsigned W = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] src0_flit, src1_flit;
  logic         src0_valid, src1_valid, src0_last, src1_last;
  logic         src0_ready, src1_ready;
  logic [W-1:0] link_flit;
  logic         link_valid;
  logic         credit_return;
  logic [5:0]   credits;
  logic [1:0]   grant;
  logic         credit_err;

  int checks = 0;
  int errors = 0;

  link_credit_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .i_src0_flit       (src0_flit),
    .i_src1_flit       (src1_flit),
    .i_src0_valid      (src0_valid),
    .i_src1_valid      (src1_valid),
    .i_src0_last       (src0_last),
    .i_src1_last       (src1_last),
    .o_src0_ready      (src0_ready),
    .o_src1_ready      (src1_ready),
    .o_link_flit       (link_flit),
    .o_link_flit_valid (link_valid),
    .i_credit_return   (credit_return),
    .o_credits         (credits),
    .o_grant           (grant),
    .o_credit_err      (credit_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic fail(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    errors++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_flit;
    logic [1:0]   exp_grant;

    rst = 1'b1;
    src0_flit = '0; src1_flit = '0;
    src0_valid = 1'b0; src1_valid = 1'b0;
    src0_last = 1'b0; src1_last = 1'b0;
    credit_return = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (grant !== 2'b00) fail("reset_grant", grant, 2'b00);
    checks++; if (credits !== 6'd32) fail("reset_credits", credits, 6'd32);
    checks++; if (link_valid !== 1'b0) fail("reset_link_valid", link_valid, 1'b0);
    checks++; if (link_flit !== 40'h0) fail("reset_link_flit", link_flit, 40'h0);
    checks++; if (credit_err !== 1'b0) fail("reset_err", credit_err, 1'b0);
    rst = 1'b0;
    tick();

    // Tie of single-flit packets: 0,1,0,1.
    src0_valid = 1'b1; src1_valid = 1'b1;
    src0_last = 1'b1; src1_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      src0_flit = 40'hA0 + 40'(k);
      src1_flit = 40'hB0 + 40'(k);
      exp_flit  = (k % 2 == 0) ? 40'hA0 + 40'(k) : 40'hB0 + 40'(k);
      exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (grant !== exp_grant) fail("tie_grant", grant, exp_grant);
      checks++; if (credits !== 6'(32 - k)) fail("tie_credits", credits, 6'(32 - k));
      tick();
      checks++; if (link_valid !== 1'b1) fail("tie_link_valid", link_valid, 1'b1);
      checks++; if (link_flit !== exp_flit) fail("tie_link_flit", link_flit, exp_flit);
    end
    checks++; if (credits !== 6'd28) fail("tie_credits_end", credits, 6'd28);
    src0_valid = 1'b0; src1_valid = 1'b0;
    tick();
    checks++; if (link_valid !== 1'b0) fail("idle_link_valid", link_valid, 1'b0);
    checks++; if (link_flit !== 40'hB3) fail("idle_link_hold", link_flit, 40'hB3);

    // Packet lock: src0 3 flits while src1 waits.
    src1_valid = 1'b1; src1_last = 1'b1; src1_flit = 40'hD1;
    src0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      src0_flit = 40'hC1 + 40'(k);
      src0_last = (k == 2);
      #1;
      checks++; if (src0_ready !== 1'b1) fail("lock_src0_ready", src0_ready, 1'b1);
      checks++; if (src1_ready !== 1'b0) fail("lock_src1_ready", src1_ready, 1'b0);
      checks++; if (grant !== 2'b01) fail("lock_grant", grant, 2'b01);
      tick();
      exp_flit = 40'hC1 + 40'(k);
      checks++; if (link_flit !== exp_flit) fail("lock_link_flit", link_flit, exp_flit);
      checks++; if (link_valid !== 1'b1) fail("lock_link_valid", link_valid, 1'b1);
    end
    #1;
    checks++; if (grant !== 2'b10) fail("after_lock_grant", grant, 2'b10);
    checks++; if (src1_ready !== 1'b1) fail("after_lock_src1_ready", src1_ready, 1'b1);
    tick();
    checks++; if (link_flit !== 40'hD1) fail("after_lock_link_flit", link_flit, 40'hD1);
    checks++; if (credits !== 6'd24) fail("after_lock_credits", credits, 6'd24);
    src0_valid = 1'b0; src1_valid = 1'b0;

    // Credit exhaustion from a full counter.
    pulse_reset();
    tick();
    src0_valid = 1'b1; src0_last = 1'b1;
    for (int k = 0; k < 32; k++) begin
      src0_flit = 40'h100 + 40'(k);
      #1;
      checks++; if (src0_ready !== 1'b1) fail("exhaust_ready", src0_ready, 1'b1);
      tick();
    end
    checks++; if (credits !== 6'd0) fail("exhaust_credits", credits, 6'd0);
    checks++; if (src0_ready !== 1'b0) fail("exhaust_ready_zero", src0_ready, 1'b0);
    checks++; if (grant !== 2'b00) fail("exhaust_grant", grant, 2'b00);
    checks++; if (link_flit !== 40'h11F) fail("exhaust_last_flit", link_flit, 40'h11F);
    credit_return = 1'b1;
    src0_flit = 40'h200;
    #1;
    checks++; if (src0_ready !== 1'b0) fail("return_same_cycle_ready", src0_ready, 1'b0);
    tick();
    credit_return = 1'b0;
    checks++; if (link_valid !== 1'b0) fail("exhaust_link_idle", link_valid, 1'b0);
    checks++; if (credits !== 6'd1) fail("return_credits", credits, 6'd1);
    checks++; if (src0_ready !== 1'b1) fail("return_next_ready", src0_ready, 1'b1);
    tick();
    checks++; if (link_flit !== 40'h200) fail("return_accept_link", link_flit, 40'h200);
    checks++; if (link_valid !== 1'b1) fail("return_accept_valid", link_valid, 1'b1);
    checks++; if (credits !== 6'd0) fail("return_credits_zero", credits, 6'd0);
    checks++; if (src0_ready !== 1'b0) fail("return_ready_zero", src0_ready, 1'b0);
    src0_valid = 1'b0;

    // Build up to 10 credits, then consume and return together.
    credit_return = 1'b1;
    repeat (10) tick();
    credit_return = 1'b0;
    checks++; if (credits !== 6'd10) fail("ten_credits", credits, 6'd10);
    src0_valid = 1'b1; src0_last = 1'b1; credit_return = 1'b1;
    #1;
    checks++; if (src0_ready !== 1'b1) fail("simul_ready", src0_ready, 1'b1);
    tick();
    src0_valid = 1'b0; credit_return = 1'b0;
    checks++; if (credits !== 6'd10) fail("simul_credits", credits, 6'd10);

    // Overflow at full count.
    pulse_reset();
    tick();
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    checks++; if (credits !== 6'd32) fail("ovf_credits", credits, 6'd32);
    checks++; if (credit_err !== 1'b1) fail("ovf_err", credit_err, 1'b1);
    tick();
    checks++; if (credit_err !== 1'b1) fail("ovf_err_sticky", credit_err, 1'b1);

    // Reset in the middle of a src1 packet.
    src1_valid = 1'b1; src1_last = 1'b0; src1_flit = 40'hE1;
    #1;
    checks++; if (grant !== 2'b10) fail("mid_grant_first", grant, 2'b10);
    tick();
    src0_valid = 1'b1; src0_last = 1'b1; src0_flit = 40'hF0;
    src1_flit = 40'hE2;
    #1;
    checks++; if (src0_ready !== 1'b0) fail("mid_src0_blocked", src0_ready, 1'b0);
    tick();
    checks++; if (link_flit !== 40'hE2) fail("mid_link_flit", link_flit, 40'hE2);
    checks++; if (credit_err !== 1'b1) fail("mid_err_held", credit_err, 1'b1);
    rst = 1'b1;
    #1;
    checks++; if (grant !== 2'b00) fail("rst_grant", grant, 2'b00);
    checks++; if (credits !== 6'd32) fail("rst_credits", credits, 6'd32);
    checks++; if (link_valid !== 1'b0) fail("rst_link_valid", link_valid, 1'b0);
    checks++; if (credit_err !== 1'b0) fail("rst_err", credit_err, 1'b0);
    checks++; if (src1_ready !== 1'b0) fail("rst_src1_ready", src1_ready, 1'b0);
    rst = 1'b0;
    src1_last = 1'b1;
    #1;
    checks++; if (grant !== 2'b01) fail("post_rst_grant", grant, 2'b01);
    tick();
    checks++; if (link_flit !== 40'hF0) fail("post_rst_link_flit", link_flit, 40'hF0);
    src0_valid = 1'b0; src1_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
